// File: rtl/toy_dmem_responder.sv
// RISC_TOY data-memory slave: single-port word array with a registered 1-cycle read path.
// Define DMEM_WRBUF_EN to add the posted-write buffer, its idle-cycle drain and read forwarding.
module toy_dmem_responder #(
  parameter int AW       = 10,
  parameter int WB_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        DREQ,
  input  logic        DRW,
  input  logic [29:0] DADDR,
  input  logic [31:0] DWDATA,
  output logic [31:0] DRDATA,
  output logic        DERR,
  output logic        WB_EMPTY
);

  localparam int DEPTH = 1 << AW;

  if (WB_DEPTH < 2 || (WB_DEPTH & (WB_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("WB_DEPTH must be a power of two >= 2");
  end

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] addr;
  logic          in_range;
  logic          rd_req;
  logic          wr_req;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   rd_val;
  logic [31:0]   drdata_q, drdata_d;
  logic          derr_q, derr_d;

  assign addr     = DADDR[AW-1:0];
  assign in_range = (DADDR[29:AW] == '0);
  assign rd_req   = DREQ && !DRW;
  assign wr_req   = DREQ && DRW && in_range;

`ifdef DMEM_WRBUF_EN
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] wb_addr_q [WB_DEPTH];
  logic [31:0]   wb_data_q [WB_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wb_empty_q;
  logic          full;
  logic          drain;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [PW-1:0] idx;

  // The array port is free on idle cycles; a write into a full buffer steals it to retire the head.
  assign full  = (cnt_q == CW'(WB_DEPTH));
  assign drain = (cnt_q != '0) && (!DREQ || (wr_req && full));

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (drain)  head_d = head_q + PW'(1);
    if (wr_req) tail_d = tail_q + PW'(1);
    cnt_d = cnt_q + CW'(wr_req) - CW'(drain);
  end

  // Scan oldest to newest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < cnt_q) && (wb_addr_q[idx] == addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[idx];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      wb_empty_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      wb_empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_req) begin
      wb_addr_q[tail_q] <= addr;
      wb_data_q[tail_q] <= DWDATA;
    end
  end

  assign mem_we    = drain;
  assign mem_waddr = wb_addr_q[head_q];
  assign mem_wdata = wb_data_q[head_q];
  assign rd_val    = fwd_hit ? fwd_data : mem[addr];
  assign WB_EMPTY  = wb_empty_q;
`else
  assign mem_we    = wr_req;
  assign mem_waddr = addr;
  assign mem_wdata = DWDATA;
  assign rd_val    = mem[addr];
  assign WB_EMPTY  = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    drdata_d = drdata_q;
    if (rd_req) drdata_d = in_range ? rd_val : '0;
    derr_d = DREQ && !in_range;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      drdata_q <= '0;
      derr_q   <= 1'b0;
    end else begin
      drdata_q <= drdata_d;
      derr_q   <= derr_d;
    end
  end

  assign DRDATA = drdata_q;
  assign DERR   = derr_q;

endmodule

// File: tb/tb_toy_dmem_responder.sv
// Scoreboard bench for toy_dmem_responder; works in both DMEM_WRBUF_EN builds.
module tb_toy_dmem_responder;
  localparam int AW       = 10;
  localparam int WB_DEPTH = 4;
`ifdef DMEM_WRBUF_EN
  localparam bit HAS_WB = 1'b1;
`else
  localparam bit HAS_WB = 1'b0;
`endif

  logic        CLK    = 1'b0;
  logic        RSTN   = 1'b0;
  logic        DREQ   = 1'b0;
  logic        DRW    = 1'b0;
  logic [29:0] DADDR  = '0;
  logic [31:0] DWDATA = '0;
  logic [31:0] DRDATA;
  logic        DERR;
  logic        WB_EMPTY;

  int checks   = 0;
  int failures = 0;

  typedef struct packed { logic req; logic rw; logic [29:0] a; logic [31:0] d; } step_t;
  typedef struct packed { logic [29:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic [31:0] d; logic e; logic emp; } exp_t;

  logic [31:0] arr_m [logic [29:0]];
  wr_t         pend_q[$];
  exp_t        exp_q[$];
  logic [31:0] last_rd = '0;

  toy_dmem_responder #(.AW(AW), .WB_DEPTH(WB_DEPTH)) dut (
    .CLK(CLK), .RSTN(RSTN), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
    .DWDATA(DWDATA), .DRDATA(DRDATA), .DERR(DERR), .WB_EMPTY(WB_EMPTY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic step_t st_wr(input logic [29:0] a, input logic [31:0] d);
    step_t s; s.req = 1'b1; s.rw = 1'b1; s.a = a; s.d = d; return s;
  endfunction
  function automatic step_t st_rd(input logic [29:0] a);
    step_t s; s.req = 1'b1; s.rw = 1'b0; s.a = a; s.d = '0; return s;
  endfunction
  function automatic step_t st_idle();
    step_t s; s.req = 1'b0; s.rw = 1'b0; s.a = '0; s.d = '0; return s;
  endfunction

  // Drives one request cycle, advances the reference model and queues the expected outputs.
  task automatic drive(input step_t s);
    logic inr;
    logic [31:0] rv;
    wr_t w;
    exp_t x;
    inr = ((s.a >> AW) == 30'd0);
    DREQ = s.req; DRW = s.rw; DADDR = s.a; DWDATA = s.d;
    if (s.req && !s.rw) begin
      rv = '0;
      if (inr) begin
        if (arr_m.exists(s.a)) rv = arr_m[s.a];
        foreach (pend_q[i]) if (pend_q[i].a == s.a) rv = pend_q[i].d;
      end
      last_rd = rv;
    end
    if (HAS_WB) begin
      if (!s.req && pend_q.size() > 0) begin
        w = pend_q.pop_front(); arr_m[w.a] = w.d;
      end else if (s.req && s.rw && inr) begin
        if (pend_q.size() == WB_DEPTH) begin
          w = pend_q.pop_front(); arr_m[w.a] = w.d;
        end
        w.a = s.a; w.d = s.d; pend_q.push_back(w);
      end
    end else if (s.req && s.rw && inr) begin
      arr_m[s.a] = s.d;
    end
    x.d = last_rd; x.e = s.req && !inr; x.emp = (pend_q.size() == 0);
    exp_q.push_back(x);
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    checks++; if (DRDATA !== 32'h0) begin failures++; $display("FAIL reset_drdata got=%h want=0", DRDATA); end
    checks++; if (DERR !== 1'b0) begin failures++; $display("FAIL reset_derr got=%b want=0", DERR); end
    checks++; if (WB_EMPTY !== 1'b1) begin failures++; $display("FAIL reset_wbempty got=%b want=1", WB_EMPTY); end
  endtask

  task automatic test_raw();
    step_t s[$];
    exp_t x;
    s.push_back(st_wr(30'd5, 32'h1234_5678));
    s.push_back(st_rd(30'd5));
    s.push_back(st_idle());
    foreach (s[i]) begin
      drive(s[i]);
      x = exp_q.pop_front();
      checks++; if (DRDATA !== x.d) begin failures++; $display("FAIL raw[%0d] DRDATA got=%h want=%h", i, DRDATA, x.d); end
      checks++; if (DERR !== x.e) begin failures++; $display("FAIL raw[%0d] DERR got=%b want=%b", i, DERR, x.e); end
      checks++; if (WB_EMPTY !== x.emp) begin failures++; $display("FAIL raw[%0d] WB_EMPTY got=%b want=%b", i, WB_EMPTY, x.emp); end
      if (i == 1) begin
        checks++; if (DRDATA !== 32'h1234_5678) begin failures++; $display("FAIL raw_const DRDATA got=%h want=12345678", DRDATA); end
      end
    end
  endtask

  task automatic test_wrbuf_fill();
    step_t s[$];
    exp_t x;
    for (int k = 0; k < 6; k++) s.push_back(st_wr(30'(k), 32'hA0 + 32'(k)));
    for (int k = 0; k < 4; k++) s.push_back(st_rd(30'd0));
    for (int k = 0; k < 4; k++) s.push_back(st_idle());
    for (int k = 0; k < 6; k++) s.push_back(st_rd(30'(k)));
    foreach (s[i]) begin
      drive(s[i]);
      x = exp_q.pop_front();
      checks++; if (DRDATA !== x.d) begin failures++; $display("FAIL fill[%0d] DRDATA got=%h want=%h", i, DRDATA, x.d); end
      checks++; if (DERR !== x.e) begin failures++; $display("FAIL fill[%0d] DERR got=%b want=%b", i, DERR, x.e); end
      checks++; if (WB_EMPTY !== x.emp) begin failures++; $display("FAIL fill[%0d] WB_EMPTY got=%b want=%b", i, WB_EMPTY, x.emp); end
      if (i >= 14) begin
        checks++;
        if (DRDATA !== 32'hA0 + 32'(i - 14)) begin
          failures++; $display("FAIL fill_const[%0d] DRDATA got=%h want=%h", i, DRDATA, 32'hA0 + 32'(i - 14));
        end
      end
    end
  endtask

  task automatic test_same_addr();
    step_t s[$];
    exp_t x;
    s.push_back(st_wr(30'd9, 32'h11));
    s.push_back(st_wr(30'd9, 32'h22));
    s.push_back(st_rd(30'd9));
    for (int k = 0; k < 4; k++) s.push_back(st_idle());
    s.push_back(st_rd(30'd9));
    foreach (s[i]) begin
      drive(s[i]);
      x = exp_q.pop_front();
      checks++; if (DRDATA !== x.d) begin failures++; $display("FAIL order[%0d] DRDATA got=%h want=%h", i, DRDATA, x.d); end
      checks++; if (DERR !== x.e) begin failures++; $display("FAIL order[%0d] DERR got=%b want=%b", i, DERR, x.e); end
      checks++; if (WB_EMPTY !== x.emp) begin failures++; $display("FAIL order[%0d] WB_EMPTY got=%b want=%b", i, WB_EMPTY, x.emp); end
      if (i == 2 || i == 7) begin
        checks++; if (DRDATA !== 32'h22) begin failures++; $display("FAIL order_const[%0d] DRDATA got=%h want=22", i, DRDATA); end
      end
    end
  endtask

  task automatic test_out_of_range();
    step_t s[$];
    exp_t x;
    s.push_back(st_wr(30'h400, 32'hDEAD));
    s.push_back(st_idle());
    s.push_back(st_rd(30'h400));
    s.push_back(st_idle());
    s.push_back(st_rd(30'd0));
    foreach (s[i]) begin
      drive(s[i]);
      x = exp_q.pop_front();
      checks++; if (DRDATA !== x.d) begin failures++; $display("FAIL oor[%0d] DRDATA got=%h want=%h", i, DRDATA, x.d); end
      checks++; if (DERR !== x.e) begin failures++; $display("FAIL oor[%0d] DERR got=%b want=%b", i, DERR, x.e); end
      checks++; if (WB_EMPTY !== x.emp) begin failures++; $display("FAIL oor[%0d] WB_EMPTY got=%b want=%b", i, WB_EMPTY, x.emp); end
      if (i == 2) begin
        checks++; if (DRDATA !== 32'h0) begin failures++; $display("FAIL oor_const DRDATA got=%h want=0", DRDATA); end
      end
      if (i == 4) begin
        checks++; if (DRDATA !== 32'hA0) begin failures++; $display("FAIL oor_prior DRDATA got=%h want=a0", DRDATA); end
      end
    end
  endtask

  task automatic test_full_interleave();
    step_t s[$];
    exp_t x;
    for (int k = 0; k < 4; k++) s.push_back(st_wr(30'd20 + 30'(k), 32'h20 + 32'(k)));
    s.push_back(st_wr(30'd7, 32'h77));
    s.push_back(st_rd(30'd7));
    for (int k = 0; k < 4; k++) s.push_back(st_idle());
    s.push_back(st_rd(30'd7));
    s.push_back(st_rd(30'd20));
    foreach (s[i]) begin
      drive(s[i]);
      x = exp_q.pop_front();
      checks++; if (DRDATA !== x.d) begin failures++; $display("FAIL full[%0d] DRDATA got=%h want=%h", i, DRDATA, x.d); end
      checks++; if (DERR !== x.e) begin failures++; $display("FAIL full[%0d] DERR got=%b want=%b", i, DERR, x.e); end
      checks++; if (WB_EMPTY !== x.emp) begin failures++; $display("FAIL full[%0d] WB_EMPTY got=%b want=%b", i, WB_EMPTY, x.emp); end
      if (i == 5 || i == 10) begin
        checks++; if (DRDATA !== 32'h77) begin failures++; $display("FAIL full_const[%0d] DRDATA got=%h want=77", i, DRDATA); end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    step_t s[$];
    exp_t x;
    for (int k = 1; k <= 3; k++) drive(st_wr(30'(k), 32'h0));
    for (int k = 0; k < 4; k++) drive(st_idle());
    for (int k = 1; k <= 3; k++) drive(st_wr(30'(k), 32'hB0 + 32'(k)));
    exp_q.delete();
    DREQ = 1'b0;
    RSTN = 1'b0;
    pend_q.delete();
    last_rd = '0;
    @(posedge CLK); #1;
    RSTN = 1'b1;
    checks++; if (DRDATA !== 32'h0) begin failures++; $display("FAIL midrst DRDATA got=%h want=0", DRDATA); end
    checks++; if (WB_EMPTY !== 1'b1) begin failures++; $display("FAIL midrst WB_EMPTY got=%b want=1", WB_EMPTY); end
    checks++; if (DERR !== 1'b0) begin failures++; $display("FAIL midrst DERR got=%b want=0", DERR); end
    for (int k = 1; k <= 3; k++) s.push_back(st_rd(30'(k)));
    s.push_back(st_idle());
    foreach (s[i]) begin
      drive(s[i]);
      x = exp_q.pop_front();
      checks++; if (DRDATA !== x.d) begin failures++; $display("FAIL midrst[%0d] DRDATA got=%h want=%h", i, DRDATA, x.d); end
      checks++; if (DERR !== x.e) begin failures++; $display("FAIL midrst[%0d] DERR got=%b want=%b", i, DERR, x.e); end
      checks++; if (WB_EMPTY !== x.emp) begin failures++; $display("FAIL midrst[%0d] WB_EMPTY got=%b want=%b", i, WB_EMPTY, x.emp); end
      if (i < 3) begin
        checks++;
        if (DRDATA !== (HAS_WB ? 32'h0 : 32'hB1 + 32'(i))) begin
          failures++; $display("FAIL midrst_const[%0d] DRDATA got=%h want=%h", i, DRDATA, HAS_WB ? 32'h0 : 32'hB1 + 32'(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_wrbuf_fill();
    test_same_addr();
    test_out_of_range();
    test_full_interleave();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
